e203_exu_excp_seq: RTL and testbench
====================================

E203_EXU_EXCP_SEQ -- requirements
Module: e203_exu_excp_seq

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- longp_excp_valid  in  1  long-pipe exception request
- longp_cause  in  4  long-pipe cause
- longp_pc  in  32  long-pipe faulting PC
- alu_excp_valid  in  1  ALU exception request
- alu_cause  in  4  ALU cause
- alu_pc  in  32  ALU faulting PC
- irq_pending  in  1  enabled interrupt pending
- irq_cause  in  4  interrupt cause
- dbg_req  in  1  debug entry request
- wfi_cmt  in  1  WFI instruction committing
- oitf_empty  in  1  no outstanding long-pipe ops
- csr_mtvec_r  in  32  trap vector base
- flush_ack  in  1  IFU accepts flush
- wfi_halt_ifu_ack  in  1  IFU halted
- wfi_halt_exu_ack  in  1  EXU halted
- longp_excp_ready, alu_excp_ready  out  1 each  source accepted (1-cycle pulse)
- flush_req  out  1  flush request to IFU
- flush_pc  out  32  redirect target
- flush_cause  out  5  {is_irq, cause[3:0]}
- flush_epc  out  32  PC saved to mepc/dpc
- flush_dbg  out  1  flush is debug entry
- wfi_halt_ifu_req, wfi_halt_exu_req  out  1 each  WFI halt requests
- core_wfi  out  1  core sleeping
- excp_cnt  out  8  accepted flushes, saturating
REQ-002 SHALL use a single clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-003 SHALL implement FSM states IDLE, FLUSH, WFI_HALT, SLEEP; all outputs registered or decoded from state and latched registers.
REQ-004 In IDLE, eligibility: longp always; dbg always; irq only if oitf_empty; alu only if oitf_empty.
REQ-005 Priority among eligible requests: longp > dbg > irq > alu; only one is accepted per cycle.
REQ-006 On acceptance in IDLE: the matching *_ready pulses high in that same cycle (dbg/irq have no ready); cause/epc/pc latched; next state FLUSH.
REQ-007 Latched values: flush_pc = {csr_mtvec_r[31:2],2'b00} for longp/alu/irq, 32'h0000_0800 for dbg; flush_epc = longp_pc (longp), alu_pc (alu, irq, dbg); flush_cause = {0,longp_cause}, {0,alu_cause}, {1,irq_cause}, 5'h00 for dbg; flush_dbg = 1 only for dbg.
REQ-008 In FLUSH: flush_req = 1, latched outputs stable, all *_ready = 0; on flush_ack -> IDLE next cycle (flush_req low that cycle). Minimum flush_req width 1 cycle.
REQ-009 In IDLE with no eligible request and wfi_cmt = 1 -> WFI_HALT; an eligible request in the same cycle wins over wfi_cmt.
REQ-010 WFI_HALT: both halt reqs = 1; ifu/exu acks captured in sticky bits (may arrive in different cycles); when both captured -> SLEEP.
REQ-011 WFI_HALT or SLEEP with irq_pending or dbg_req -> IDLE next cycle; halt reqs and core_wfi drop; sticky bits clear; wake takes precedence over ack completion in the same cycle.
REQ-012 SLEEP: core_wfi = 1, halt reqs held at 1.
REQ-013 excp_cnt increments by 1 on each acceptance; saturates at 8'hFF.
REQ-014 flush_pc/epc/cause/flush_dbg hold their last latched values outside FLUSH.

Reset
REQ-015 On rst_n low, immediately (no clock): state IDLE, all outputs and registers 0, sticky acks cleared.
REQ-016 Reset during FLUSH/WFI_HALT/SLEEP aborts the operation; after release the FSM is in IDLE with flush_req = 0.

Verification
REQ-017 longp_excp_valid=1, alu_excp_valid=1, oitf_empty=1, longp_cause=5, csr_mtvec_r=32'h8000_0103 -> longp_excp_ready pulses, alu_excp_ready=0, next cycle flush_req=1, flush_pc=32'h8000_0100, flush_cause=5'h05, excp_cnt=1.
REQ-018 irq_pending=1, irq_cause=11, oitf_empty=0 for 3 cycles then 1 -> no flush for 3 cycles; then flush_cause=5'h1B; flush_req held until flush_ack, low the cycle after.
REQ-019 dbg_req=1 with irq_pending=1 -> flush_dbg=1, flush_pc=32'h0000_0800.
REQ-020 wfi_cmt=1; ifu_ack at cycle +2, exu_ack at +4 -> SLEEP, core_wfi=1 at +5; irq_pending=1 -> core_wfi and halt reqs 0 next cycle, then irq flush.
REQ-021 256 accepted flushes -> excp_cnt=8'hFF and stays; rst_n low mid-FLUSH -> flush_req=0 and excp_cnt=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/e203_exu_excp_seq.sv
// Exception/interrupt/debug flush sequencer with WFI halt handshake.
// Arbitrates trap sources, latches the redirect info, and sequences core sleep.
module e203_exu_excp_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        longp_excp_valid,
  input  logic [3:0]  longp_cause,
  input  logic [31:0] longp_pc,
  input  logic        alu_excp_valid,
  input  logic [3:0]  alu_cause,
  input  logic [31:0] alu_pc,
  input  logic        irq_pending,
  input  logic [3:0]  irq_cause,
  input  logic        dbg_req,
  input  logic        wfi_cmt,
  input  logic        oitf_empty,
  input  logic [31:0] csr_mtvec_r,
  input  logic        flush_ack,
  input  logic        wfi_halt_ifu_ack,
  input  logic        wfi_halt_exu_ack,
  output logic        longp_excp_ready,
  output logic        alu_excp_ready,
  output logic        flush_req,
  output logic [31:0] flush_pc,
  output logic [4:0]  flush_cause,
  output logic [31:0] flush_epc,
  output logic        flush_dbg,
  output logic        wfi_halt_ifu_req,
  output logic        wfi_halt_exu_req,
  output logic        core_wfi,
  output logic [7:0]  excp_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    WFI_HALT = 2'd2,
    SLEEP    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic [31:0] flush_epc_q, flush_epc_d;
  logic [4:0]  flush_cause_q, flush_cause_d;
  logic        flush_dbg_q, flush_dbg_d;
  logic [7:0]  excp_cnt_q, excp_cnt_d;
  logic        ifu_ack_q, ifu_ack_d;
  logic        exu_ack_q, exu_ack_d;

  logic        is_idle;
  logic        acc_longp, acc_dbg, acc_irq, acc_alu, acc_any;
  logic [31:0] mtvec_base;

  // Fixed priority: longp > dbg > irq > alu; irq/alu wait for the long pipe to drain.
  assign is_idle    = (state_q == IDLE);
  assign acc_longp  = is_idle & longp_excp_valid;
  assign acc_dbg    = is_idle & ~longp_excp_valid & dbg_req;
  assign acc_irq    = is_idle & ~longp_excp_valid & ~dbg_req & irq_pending & oitf_empty;
  assign acc_alu    = is_idle & ~longp_excp_valid & ~dbg_req & ~irq_pending
                    & alu_excp_valid & oitf_empty;
  assign acc_any    = acc_longp | acc_dbg | acc_irq | acc_alu;
  assign mtvec_base = {csr_mtvec_r[31:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    flush_pc_d    = flush_pc_q;
    flush_epc_d   = flush_epc_q;
    flush_cause_d = flush_cause_q;
    flush_dbg_d   = flush_dbg_q;
    excp_cnt_d    = excp_cnt_q;
    ifu_ack_d     = ifu_ack_q;
    exu_ack_d     = exu_ack_q;

    if (acc_any && excp_cnt_q != 8'hFF) begin
      excp_cnt_d = excp_cnt_q + 8'd1;
    end

    if (acc_longp) begin
      flush_pc_d    = mtvec_base;
      flush_epc_d   = longp_pc;
      flush_cause_d = {1'b0, longp_cause};
      flush_dbg_d   = 1'b0;
    end else if (acc_dbg) begin
      flush_pc_d    = 32'h0000_0800;
      flush_epc_d   = alu_pc;
      flush_cause_d = 5'h00;
      flush_dbg_d   = 1'b1;
    end else if (acc_irq) begin
      flush_pc_d    = mtvec_base;
      flush_epc_d   = alu_pc;
      flush_cause_d = {1'b1, irq_cause};
      flush_dbg_d   = 1'b0;
    end else if (acc_alu) begin
      flush_pc_d    = mtvec_base;
      flush_epc_d   = alu_pc;
      flush_cause_d = {1'b0, alu_cause};
      flush_dbg_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (acc_any) begin
          state_d = FLUSH;
        end else if (wfi_cmt) begin
          state_d = WFI_HALT;
        end
      end
      FLUSH: begin
        if (flush_ack) begin
          state_d = IDLE;
        end
      end
      WFI_HALT, SLEEP: begin
        // A wake request overrides any ack arriving in the same cycle.
        if (irq_pending || dbg_req) begin
          state_d   = IDLE;
          ifu_ack_d = 1'b0;
          exu_ack_d = 1'b0;
        end else if (state_q == WFI_HALT) begin
          ifu_ack_d = ifu_ack_q | wfi_halt_ifu_ack;
          exu_ack_d = exu_ack_q | wfi_halt_exu_ack;
          if (ifu_ack_d && exu_ack_d) begin
            state_d = SLEEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      flush_pc_q    <= 32'h0;
      flush_epc_q   <= 32'h0;
      flush_cause_q <= 5'h0;
      flush_dbg_q   <= 1'b0;
      excp_cnt_q    <= 8'h0;
      ifu_ack_q     <= 1'b0;
      exu_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_pc_q    <= flush_pc_d;
      flush_epc_q   <= flush_epc_d;
      flush_cause_q <= flush_cause_d;
      flush_dbg_q   <= flush_dbg_d;
      excp_cnt_q    <= excp_cnt_d;
      ifu_ack_q     <= ifu_ack_d;
      exu_ack_q     <= exu_ack_d;
    end
  end

  assign longp_excp_ready = acc_longp;
  assign alu_excp_ready   = acc_alu;
  assign flush_req        = (state_q == FLUSH);
  assign flush_pc         = flush_pc_q;
  assign flush_epc        = flush_epc_q;
  assign flush_cause      = flush_cause_q;
  assign flush_dbg        = flush_dbg_q;
  assign wfi_halt_ifu_req = (state_q == WFI_HALT) || (state_q == SLEEP);
  assign wfi_halt_exu_req = (state_q == WFI_HALT) || (state_q == SLEEP);
  assign core_wfi         = (state_q == SLEEP);
  assign excp_cnt         = excp_cnt_q;

endmodule

// File: tb/tb_e203_exu_excp_seq.sv
// Directed bench for e203_exu_excp_seq: arbitration, flush handshake, WFI sleep/wake,
// counter saturation and asynchronous reset.
module tb_e203_exu_excp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        longp_excp_valid, alu_excp_valid, irq_pending, dbg_req, wfi_cmt;
  logic [3:0]  longp_cause, alu_cause, irq_cause;
  logic [31:0] longp_pc, alu_pc, csr_mtvec_r;
  logic        oitf_empty, flush_ack, wfi_halt_ifu_ack, wfi_halt_exu_ack;
  logic        longp_excp_ready, alu_excp_ready, flush_req, flush_dbg;
  logic [31:0] flush_pc, flush_epc;
  logic [4:0]  flush_cause;
  logic        wfi_halt_ifu_req, wfi_halt_exu_req, core_wfi;
  logic [7:0]  excp_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  e203_exu_excp_seq dut (
    .clk(clk), .rst_n(rst_n),
    .longp_excp_valid(longp_excp_valid), .longp_cause(longp_cause), .longp_pc(longp_pc),
    .alu_excp_valid(alu_excp_valid), .alu_cause(alu_cause), .alu_pc(alu_pc),
    .irq_pending(irq_pending), .irq_cause(irq_cause), .dbg_req(dbg_req),
    .wfi_cmt(wfi_cmt), .oitf_empty(oitf_empty), .csr_mtvec_r(csr_mtvec_r),
    .flush_ack(flush_ack), .wfi_halt_ifu_ack(wfi_halt_ifu_ack),
    .wfi_halt_exu_ack(wfi_halt_exu_ack),
    .longp_excp_ready(longp_excp_ready), .alu_excp_ready(alu_excp_ready),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_cause(flush_cause),
    .flush_epc(flush_epc), .flush_dbg(flush_dbg),
    .wfi_halt_ifu_req(wfi_halt_ifu_req), .wfi_halt_exu_req(wfi_halt_exu_req),
    .core_wfi(core_wfi), .excp_cnt(excp_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    longp_excp_valid = 0; alu_excp_valid = 0; irq_pending = 0; dbg_req = 0; wfi_cmt = 0;
    longp_cause = 0; alu_cause = 0; irq_cause = 0;
    longp_pc = 0; alu_pc = 0; csr_mtvec_r = 0;
    oitf_empty = 0; flush_ack = 0; wfi_halt_ifu_ack = 0; wfi_halt_exu_ack = 0;
    #1;
    chk("rst_flush_req", flush_req, 0);
    chk("rst_excp_cnt", excp_cnt, 0);
    chk("rst_core_wfi", core_wfi, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_halt_req", wfi_halt_ifu_req, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // longp beats alu
    longp_excp_valid = 1; alu_excp_valid = 1; oitf_empty = 1;
    longp_cause = 4'd5; longp_pc = 32'h0000_0100; csr_mtvec_r = 32'h8000_0103;
    #1;
    chk("longp_ready_pulse", longp_excp_ready, 1);
    chk("alu_ready_blocked", alu_excp_ready, 0);
    step();
    longp_excp_valid = 0;
    #1;
    chk("longp_flush_req", flush_req, 1);
    chk("longp_flush_pc", flush_pc, 32'h8000_0100);
    chk("longp_flush_cause", flush_cause, 5'h05);
    chk("longp_flush_epc", flush_epc, 32'h0000_0100);
    chk("longp_flush_dbg", flush_dbg, 0);
    chk("longp_cnt", excp_cnt, 1);
    chk("flush_alu_ready_0", alu_excp_ready, 0);
    step();
    chk("flush_held_no_ack", flush_req, 1);
    alu_excp_valid = 0; flush_ack = 1;
    step();
    flush_ack = 0;
    chk("flush_drop_after_ack", flush_req, 0);
    chk("flush_pc_holds", flush_pc, 32'h8000_0100);

    // irq blocked while oitf not empty
    irq_pending = 1; irq_cause = 4'd11; oitf_empty = 0; alu_pc = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("irq_wait_oitf", flush_req, 0);
    end
    oitf_empty = 1;
    step();
    chk("irq_flush_req", flush_req, 1);
    chk("irq_flush_cause", flush_cause, 5'h1B);
    chk("irq_flush_epc", flush_epc, 32'h0000_0200);
    chk("irq_cnt", excp_cnt, 2);
    step();
    chk("irq_flush_held", flush_req, 1);
    flush_ack = 1; irq_pending = 0;
    step();
    flush_ack = 0;
    chk("irq_flush_drop", flush_req, 0);

    // dbg beats irq
    dbg_req = 1; irq_pending = 1;
    step();
    dbg_req = 0; irq_pending = 0;
    chk("dbg_flush_dbg", flush_dbg, 1);
    chk("dbg_flush_pc", flush_pc, 32'h0000_0800);
    chk("dbg_flush_cause", flush_cause, 5'h00);
    chk("dbg_cnt", excp_cnt, 3);
    flush_ack = 1;
    step();
    flush_ack = 0;

    // alu needs oitf empty
    alu_excp_valid = 1; alu_cause = 4'd3; oitf_empty = 0;
    #1;
    chk("alu_ready_oitf_busy", alu_excp_ready, 0);
    step();
    chk("alu_no_flush_busy", flush_req, 0);
    oitf_empty = 1;
    #1;
    chk("alu_ready_pulse", alu_excp_ready, 1);
    step();
    alu_excp_valid = 0;
    chk("alu_flush_cause", flush_cause, 5'h03);
    chk("alu_flush_dbg", flush_dbg, 0);
    chk("alu_cnt", excp_cnt, 4);
    flush_ack = 1;
    step();
    flush_ack = 0;

    // request beats wfi_cmt
    wfi_cmt = 1; longp_excp_valid = 1; longp_cause = 4'd2;
    step();
    wfi_cmt = 0; longp_excp_valid = 0;
    chk("wfi_lose_flush", flush_req, 1);
    chk("wfi_lose_halt", wfi_halt_ifu_req, 0);
    chk("wfi_lose_cnt", excp_cnt, 5);
    flush_ack = 1;
    step();
    flush_ack = 0;

    // WFI sleep with acks in different cycles, then irq wake
    wfi_cmt = 1;
    step();
    wfi_cmt = 0;
    chk("wfi_ifu_req", wfi_halt_ifu_req, 1);
    chk("wfi_exu_req", wfi_halt_exu_req, 1);
    chk("wfi_not_sleep", core_wfi, 0);
    step();
    wfi_halt_ifu_ack = 1;
    step();
    wfi_halt_ifu_ack = 0;
    chk("wfi_one_ack", core_wfi, 0);
    step();
    wfi_halt_exu_ack = 1;
    step();
    wfi_halt_exu_ack = 0;
    chk("sleep_core_wfi", core_wfi, 1);
    chk("sleep_halt_req", wfi_halt_exu_req, 1);
    step();
    chk("sleep_stays", core_wfi, 1);
    irq_pending = 1; irq_cause = 4'd7;
    step();
    chk("wake_core_wfi", core_wfi, 0);
    chk("wake_halt_ifu", wfi_halt_ifu_req, 0);
    chk("wake_halt_exu", wfi_halt_exu_req, 0);
    chk("wake_no_flush_yet", flush_req, 0);
    step();
    irq_pending = 0;
    chk("wake_irq_flush", flush_req, 1);
    chk("wake_irq_cause", flush_cause, 5'h17);
    chk("wake_cnt", excp_cnt, 6);
    flush_ack = 1;
    step();
    flush_ack = 0;

    // saturation: one acceptance every two cycles with ack held
    longp_excp_valid = 1; flush_ack = 1;
    for (int i = 0; i < 600; i++) step();
    chk("cnt_saturated", excp_cnt, 8'hFF);
    flush_ack = 0;
    step(); step();
    chk("sat_in_flush", flush_req, 1);
    chk("cnt_stays_ff", excp_cnt, 8'hFF);
    longp_excp_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flush_req", flush_req, 0);
    chk("async_rst_cnt", excp_cnt, 0);
    chk("async_rst_pc", flush_pc, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", flush_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
